// File: rtl/miner_nonce_scan_if.sv
// Handshake and data bundle between the load stage, the nonce-scan engine and the SHA-256 core.
interface miner_nonce_scan_if;
    // load-stage side
    logic         en;
    logic [255:0] prev_H;
    logic [95:0]  input_M;
    logic [255:0] prev_blk;
    logic         busy;
    logic [31:0]  nonce;
    logic [255:0] winner_H;
    logic         found;
    logic         done;
    // compression-core side
    logic         core_ready;
    logic         core_start;
    logic [255:0] core_H_in;
    logic [511:0] core_M;
    logic         core_done;
    logic [255:0] core_H_out;

    // master: load stage plus core (the environment around the engine)
    modport master (
        output en, prev_H, input_M, prev_blk, core_ready, core_done, core_H_out,
        input  busy, nonce, winner_H, found, done, core_start, core_H_in, core_M
    );

    // slave: the nonce-scan engine
    modport slave (
        input  en, prev_H, input_M, prev_blk, core_ready, core_done, core_H_out,
        output busy, nonce, winner_H, found, done, core_start, core_H_in, core_M
    );
endinterface

// File: rtl/miner_nonce_scan.sv
// Nonce-search engine: double SHA-256 per nonce through an external compression core,
// stops on the first hash strictly below the target or after NONCE_END.
module miner_nonce_scan #(
    parameter logic [31:0] NONCE_START = 32'h0000_0000,
    parameter logic [31:0] NONCE_END   = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               reset,
    miner_nonce_scan_if.slave  bus
);
    localparam logic [255:0] SHA_IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, CHECK} state_t;

    state_t         r_state, w_next;
    logic [255:0]   r_mid, r_target, r_winner, r_core_H_in;
    logic [95:0]    r_tail;
    logic [511:0]   r_core_M;
    logic [31:0]    r_nonce, w_nonce_inc;
    logic           r_busy, r_found, r_done, r_core_start;
    logic           w_accept, w_issue_go, w_hit, w_last;

    assign w_nonce_inc = r_nonce + 32'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; en is refused in the cycle done is still showing
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_issue_go = 1'b0;
        w_hit      = (r_winner < r_target);
        w_last     = (r_nonce == NONCE_END);
        case (r_state)
            IDLE:   if (bus.en && !r_done) begin
                        w_accept = 1'b1;
                        w_next   = ISSUE1;
                    end
            ISSUE1: if (bus.core_ready) begin
                        w_issue_go = 1'b1;
                        w_next     = WAIT1;
                    end
            WAIT1:  if (bus.core_done) w_next = ISSUE2;
            ISSUE2: if (bus.core_ready) begin
                        w_issue_go = 1'b1;
                        w_next     = WAIT2;
                    end
            WAIT2:  if (bus.core_done) w_next = CHECK;
            CHECK:  w_next = (w_hit || w_last) ? IDLE : ISSUE1;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: core job words are loaded on entry to an ISSUE state and held until the result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mid        <= '0;
            r_tail       <= '0;
            r_target     <= '0;
            r_winner     <= '0;
            r_nonce      <= '0;
            r_core_H_in  <= '0;
            r_core_M     <= '0;
            r_busy       <= 1'b0;
            r_found      <= 1'b0;
            r_done       <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= w_issue_go;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_mid       <= bus.prev_H;
                    r_tail      <= bus.input_M;
                    r_target    <= bus.prev_blk;
                    r_nonce     <= NONCE_START;
                    r_busy      <= 1'b1;
                    r_core_H_in <= bus.prev_H;
                    r_core_M    <= {bus.input_M, NONCE_START, 1'b1, 319'b0, 64'd640};
                end
                WAIT1: if (bus.core_done) begin
                    r_core_H_in <= SHA_IV;
                    r_core_M    <= {bus.core_H_out, 1'b1, 191'b0, 64'd256};
                end
                WAIT2: if (bus.core_done) r_winner <= bus.core_H_out;
                CHECK: begin
                    if (w_hit) begin
                        r_found <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_nonce     <= w_nonce_inc;
                        r_core_H_in <= r_mid;
                        r_core_M    <= {r_tail, w_nonce_inc, 1'b1, 319'b0, 64'd640};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.nonce      = r_nonce;
    assign bus.winner_H   = r_winner;
    assign bus.found      = r_found;
    assign bus.done       = r_done;
    assign bus.core_start = r_core_start;
    assign bus.core_H_in  = r_core_H_in;
    assign bus.core_M     = r_core_M;
endmodule

// File: tb/tb_miner_nonce_scan.sv
// Directed bench: two engines (full nonce range, and NONCE_END = 3) each with a 4-cycle core model.
module tb_miner_nonce_scan;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    miner_nonce_scan_if bus_a();
    miner_nonce_scan_if bus_b();

    miner_nonce_scan u_a (.clk(clk), .reset(reset), .bus(bus_a));
    miner_nonce_scan #(.NONCE_START(32'd0), .NONCE_END(32'd3)) u_b (.clk(clk), .reset(reset), .bus(bus_b));

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] MID  = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001;
    localparam logic [95:0]  TAIL = 96'h0102_0304_0506_0708_090A_0B0C;

    // Core model: op 1 returns a tag with the nonce in the low word, op 2 returns 100 - nonce
    function automatic logic [255:0] core_fn(input logic [511:0] m);
        if (m[63:0] == 64'd640) core_fn = {32'hDEADBEEF, 192'h0, m[415:384]};
        else                    core_fn = 256'd100 - {224'd0, m[287:256]};
    endfunction

    logic [2:0]   cnt_a = '0, cnt_b = '0;
    logic [255:0] res_a = '0, res_b = '0, mout_a = '0, mout_b = '0;
    logic         mdone_a = 1'b0, mdone_b = 1'b0, spur_a = 1'b0;
    int           starts_a = 0, starts_b = 0;

    // Core model for engine A
    always @(posedge clk) begin
        mdone_a <= 1'b0;
        if (bus_a.core_start) begin
            cnt_a    <= 3'd4;
            res_a    <= core_fn(bus_a.core_M);
            starts_a <= starts_a + 1;
        end else if (cnt_a != 3'd0) begin
            cnt_a <= cnt_a - 3'd1;
            if (cnt_a == 3'd1) begin mdone_a <= 1'b1; mout_a <= res_a; end
        end
    end

    // Core model for engine B
    always @(posedge clk) begin
        mdone_b <= 1'b0;
        if (bus_b.core_start) begin
            cnt_b    <= 3'd4;
            res_b    <= core_fn(bus_b.core_M);
            starts_b <= starts_b + 1;
        end else if (cnt_b != 3'd0) begin
            cnt_b <= cnt_b - 3'd1;
            if (cnt_b == 3'd1) begin mdone_b <= 1'b1; mout_b <= res_b; end
        end
    end

    assign bus_a.core_done  = mdone_a | spur_a;
    assign bus_a.core_H_out = spur_a ? {8{32'hBAD0BAD0}} : mout_a;
    assign bus_b.core_done  = mdone_b;
    assign bus_b.core_H_out = mout_b;

    typedef struct {
        logic [255:0] target;
        logic [95:0]  tail;
        logic [255:0] mid;
        logic         exp_found;
        logic [31:0]  exp_nonce;
        logic [255:0] exp_w;
        int           exp_starts;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start_a(input logic [255:0] target, input logic [255:0] mid, input logic [95:0] tail);
        bus_a.prev_blk = target;
        bus_a.prev_H   = mid;
        bus_a.input_M  = tail;
        @(negedge clk) bus_a.en = 1'b1;
        @(negedge clk) bus_a.en = 1'b0;
    endtask

    task automatic wait_done_a(output bit got, output logic f, output logic [31:0] n, output logic [255:0] w);
        got = 1'b0; f = 1'b0; n = '0; w = '0;
        for (int i = 0; i < 2000; i++) begin
            if (bus_a.done) begin
                got = 1'b1; f = bus_a.found; n = bus_a.nonce; w = bus_a.winner_H;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_a(input logic [63:0] len, input logic [31:0] nce, input bit use_nce, input bit need_start, output bit got);
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus_a.core_M[63:0] == len && (!use_nce || bus_a.core_M[415:384] == nce) &&
                (!need_start || bus_a.core_start)) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit           got;
        logic         f;
        logic [31:0]  n;
        logic [255:0] w;
        logic [511:0] m_hold;
        int           s0;

        vecs[0] = '{256'd97,       TAIL,           MID,    1'b1, 32'd4, 256'd96,  10};
        vecs[1] = '{256'd101,      96'hA5A5,       ~MID,   1'b1, 32'd0, 256'd100, 2};
        vecs[2] = '{256'd100,      TAIL,           256'd7, 1'b1, 32'd1, 256'd99,  4};
        vecs[3] = '{256'd99,       ~TAIL,          MID,    1'b1, 32'd2, 256'd98,  6};
        vecs[4] = '{256'd1 << 255, 96'h0,          '0,     1'b1, 32'd0, 256'd100, 2};

        reset = 1'b1;
        bus_a.en = 1'b0; bus_a.prev_H = '0; bus_a.input_M = '0; bus_a.prev_blk = '0; bus_a.core_ready = 1'b1;
        bus_b.en = 1'b0; bus_b.prev_H = '0; bus_b.input_M = '0; bus_b.prev_blk = '0; bus_b.core_ready = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy",   bus_a.busy, 0);
        chk("rst_done",   bus_a.done, 0);
        chk("rst_found",  bus_a.found, 0);
        chk("rst_start",  bus_a.core_start, 0);
        chk("rst_nonce",  bus_a.nonce, 0);
        chk("rst_winner", bus_a.winner_H, 0);
        chk("rst_coreM",  bus_a.core_M[255:0], 0);
        chk("rst_Hin",    bus_a.core_H_in, 0);
        reset = 1'b0;
        @(negedge clk);

        // table-driven searches on engine A
        for (int i = 0; i < 5; i++) begin
            s0 = starts_a;
            start_a(vecs[i].target, vecs[i].mid, vecs[i].tail);
            chk("busy_after_en", bus_a.busy, 1);
            chk("m_tail",   bus_a.core_M[511:416], vecs[i].tail);
            chk("m_nonce",  bus_a.core_M[415:384], 0);
            chk("m_pad",    {bus_a.core_M[383:64], 192'h0}, {1'b1, 319'b0, 192'h0});
            chk("m_len",    bus_a.core_M[63:0], 640);
            chk("h_in_mid", bus_a.core_H_in, vecs[i].mid);
            wait_done_a(got, f, n, w);
            chk("done_seen", got, 1);
            chk("found",  f, vecs[i].exp_found);
            chk("nonce",  n, vecs[i].exp_nonce);
            chk("winner", w, vecs[i].exp_w);
            chk("starts", 256'(starts_a - s0), 256'(vecs[i].exp_starts));
            chk("busy_at_done", bus_a.busy, 0);
            @(negedge clk);
            chk("done_pulse", bus_a.done, 0);
            chk("found_pulse", bus_a.found, 0);
            chk("nonce_hold", bus_a.nonce, vecs[i].exp_nonce);
        end

        // backpressure: core_ready low for 7 cycles in the first ISSUE2
        s0 = starts_a;
        start_a(256'd97, MID, TAIL);
        wait_a(64'd256, 32'd0, 1'b0, 1'b0, got);
        chk("bp_reach_issue2", got, 1);
        bus_a.core_ready = 1'b0;
        m_hold = bus_a.core_M;
        repeat (7) begin
            @(negedge clk);
            chk("bp_no_start", bus_a.core_start, 0);
            chk("bp_M_stable", bus_a.core_M[511:256], m_hold[511:256]);
        end
        bus_a.core_ready = 1'b1;
        wait_done_a(got, f, n, w);
        chk("bp_done", got, 1);
        chk("bp_found", f, 1);
        chk("bp_nonce", n, 4);
        chk("bp_winner", w, 96);
        chk("bp_starts", 256'(starts_a - s0), 256'd10);
        @(negedge clk);

        // en while busy with different inputs, plus spurious core_done in ISSUE1
        s0 = starts_a;
        start_a(256'd97, MID, TAIL);
        repeat (3) @(negedge clk);
        bus_a.prev_blk = '0; bus_a.prev_H = '1; bus_a.input_M = '1;
        bus_a.en = 1'b1;
        @(negedge clk) bus_a.en = 1'b0;
        wait_a(64'd640, 32'd1, 1'b1, 1'b0, got);
        chk("sp_reach_issue1", got, 1);
        chk("sp_mid_latched", bus_a.core_H_in, MID);
        chk("sp_tail_latched", bus_a.core_M[511:416], TAIL);
        bus_a.core_ready = 1'b0;
        spur_a = 1'b1;
        @(negedge clk);
        spur_a = 1'b0;
        bus_a.core_ready = 1'b1;
        chk("sp_M_intact", bus_a.core_M[63:0], 640);
        wait_done_a(got, f, n, w);
        chk("sp_done", got, 1);
        chk("sp_found", f, 1);
        chk("sp_nonce", n, 4);
        chk("sp_winner", w, 96);
        chk("sp_starts", 256'(starts_a - s0), 256'd10);
        @(negedge clk);

        // reset in WAIT2, then a clean search
        start_a(256'd97, MID, TAIL);
        wait_a(64'd256, 32'd0, 1'b0, 1'b1, got);
        chk("rs_reach_wait2", got, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_busy", bus_a.busy, 0);
        chk("rs_start", bus_a.core_start, 0);
        chk("rs_nonce", bus_a.nonce, 0);
        chk("rs_done", bus_a.done, 0);
        repeat (8) @(negedge clk);
        chk("rs_idle", bus_a.busy, 0);
        start_a(256'd99, MID, TAIL);
        wait_done_a(got, f, n, w);
        chk("rs2_done", got, 1);
        chk("rs2_nonce", n, 2);
        chk("rs2_winner", w, 98);
        @(negedge clk);

        // exhaust on engine B, with en landing on the done cycle
        s0 = starts_b;
        bus_b.prev_blk = '0; bus_b.prev_H = MID; bus_b.input_M = TAIL;
        @(negedge clk) bus_b.en = 1'b1;
        @(negedge clk) bus_b.en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (bus_b.done) got = 1'b1;
        end
        chk("ex_done", got, 1);
        chk("ex_found", bus_b.found, 0);
        chk("ex_nonce", bus_b.nonce, 3);
        chk("ex_starts", 256'(starts_b - s0), 256'd8);
        bus_b.en = 1'b1;
        @(negedge clk);
        bus_b.en = 1'b0;
        chk("ex_en_on_done_ignored", bus_b.busy, 0);
        chk("ex_nonce_hold", bus_b.nonce, 3);
        @(negedge clk);
        chk("ex_still_idle", bus_b.busy, 0);
        chk("ex_no_start", bus_b.core_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
